mux_arb_reg: RTL and testbench
==============================

Name: mux_arb_reg

Overview:
- Registered, parametrised N:1 multiplexer. It is the clocked successor of the team's 2:1 combinational mux.
- It selects one of NCH input channels of WIDTH bits in one of two modes:
  - fixed-select, driven by sel_in;
  - round-robin arbitration among valid channels.
- Valid/ready handshake on every input and on the output. One output register stage.
- Sits between multiple producers and a single shared consumer.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- NCH, 4, number of input channels (>=2).
- SEL_W, $clog2(NCH), select/grant index width. This is a localparam and is not overridable.

Ports:
- clk_in  input  1  rising-edge clock
- rst_n_in  input  1  asynchronous active-low reset
- mode_in  input  1  0 = fixed-select, 1 = round-robin
- sel_in  input  SEL_W  channel index used in fixed-select mode
- valid_in  input  NCH  per-channel data valid
- data_in  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- ready_out  output  NCH  per-channel accept; one-hot or zero
- y_out  output  WIDTH  registered selected data
- y_valid_out  output  1  y_out holds a valid word
- y_ready_in  input  1  consumer accepts y_out
- grant_out  output  SEL_W  index of the channel whose word is in y_out

Behaviour:
- Reset (async assert, sync-safe deassert):
  - y_out = 0, y_valid_out = 0, grant_out = 0.
  - Round-robin pointer ptr = NCH-1, so the first search starts at channel 0.
  - Reset mid-operation discards any held word.
- Output slot free (combinational): free = !y_valid_out | y_ready_in.
- Arbitration (combinational, evaluated every cycle):
  - Fixed mode: candidate = sel_in. Grant only if sel_in < NCH and valid_in[sel_in]=1. If sel_in >= NCH, never grant.
  - Round-robin mode: candidate = first i with valid_in[i]=1, searching ptr+1, ptr+2, … modulo NCH (wraps NCH-1 -> 0). No valid channel means no grant.
- ready_out[i] = free & grant_valid & (candidate == i). ready_out is all-zero when there is no grant. It does not depend on valid_in of other channels beyond the arbitration result.
- Transfer on channel i (valid_in[i] & ready_out[i] at a rising edge):
  - y_out <= data_in[i], y_valid_out <= 1, grant_out <= i.
  - In round-robin mode only, ptr <= i.
- If free and no grant: y_valid_out <= 0; y_out and grant_out hold their last values.
- Backpressure: while y_valid_out=1 and y_ready_in=0, the following are stable and ready_out is all-zero:
  - y_out, grant_out, y_valid_out.
- Simultaneous events:
  - Output accepted and new input accepted in the same cycle gives a back-to-back transfer with no bubble. Throughput is 1 word/cycle with y_ready_in held high.
- Latency: 1 cycle from input handshake to y_valid_out.
- Mode change:
  - Takes effect in the same cycle's arbitration.
  - ptr is retained across mode changes and is not updated by fixed-mode grants.
- Inputs must hold valid_in/data_in until accepted. The block does not check this.

Decomposition:
- Shared package mux_pkg:
  - mode encodings MODE_FIXED=1'b0, MODE_RR=1'b1;
  - default WIDTH/NCH constants.
- One sub-module rr_arbiter:
  - inputs: request vector, ptr;
  - outputs: grant_valid, grant index;
  - purely combinational; parametrised by NCH.
- The top level holds the output register, the ptr register and the fixed-mode select path.

Test Plan:
- Reset, then fixed mode, NCH=4, WIDTH=8, sel_in=2, valid_in=4'b0100, data ch2=8'hA5, y_ready_in=1:
  - ready_out=4'b0100;
  - next cycle y_out=8'hA5, y_valid_out=1, grant_out=2.
- Round-robin with valid_in=4'b1111 held, data ch_i = 8'h10+i, y_ready_in=1:
  - grant_out sequence 0,1,2,3,0;
  - y_out sequence 10,11,12,13,10 on consecutive cycles, with no bubbles.
- Backpressure: word 8'h3C in y_out, y_ready_in=0 for 3 cycles:
  - y_out=8'h3C, y_valid_out=1, ready_out=0 throughout;
  - y_ready_in=1 gives the next granted word on the following cycle.
- Fixed mode, sel_in=1, valid_in=4'b1101 (ch1 idle):
  - ready_out=0;
  - y_valid_out falls to 0 after the pending word drains.
- Round-robin, last grant ch3, then valid_in=4'b0101:
  - grant goes to ch0 (wrap), then ch2, then ch0.
- Assert rst_n_in mid-stream while y_valid_out=1 and y_ready_in=0:
  - y_valid_out=0, y_out=0, grant_out=0 immediately;
  - after release the first round-robin grant is ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 mux/arbiter.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo NCH.
module rr_arbiter #(
    parameter  int NCH   = 4,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant
);

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        // ptr itself is searched last, so the most recent winner has lowest priority
        for (int k = 1; k <= NCH; k++) begin
            if (!grant_valid && req[(int'(ptr) + k) % NCH]) begin
                grant_valid = 1'b1;
                grant       = SEL_W'((int'(ptr) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N:1 mux with fixed-select or round-robin channel choice and
// valid/ready handshakes on every input and on the single output slot.
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NCH   = DEF_NCH,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 mode_in,
    input  logic [SEL_W-1:0]     sel_in,
    input  logic [NCH-1:0]       valid_in,
    input  logic [NCH*WIDTH-1:0] data_in,
    output logic [NCH-1:0]       ready_out,
    output logic [WIDTH-1:0]     y_out,
    output logic                 y_valid_out,
    input  logic                 y_ready_in,
    output logic [SEL_W-1:0]     grant_out
);

    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_grant;
    logic [SEL_W-1:0] r_ptr;

    logic             w_free;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_grant;
    logic             w_fix_valid;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_cand;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data_sel;

    rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
        .req         (valid_in),
        .ptr         (r_ptr),
        .grant_valid (w_rr_valid),
        .grant       (w_rr_grant)
    );

    // An out-of-range select (non power-of-two NCH) never grants
    always_comb begin
        w_fix_valid = 1'b0;
        if (int'(sel_in) < NCH) begin
            w_fix_valid = valid_in[sel_in];
        end
    end

    assign w_free      = !r_y_valid || y_ready_in;
    assign w_gnt_valid = (mode_in == MODE_RR) ? w_rr_valid : w_fix_valid;
    assign w_cand      = (mode_in == MODE_RR) ? w_rr_grant : sel_in;
    assign w_xfer      = w_free && w_gnt_valid;
    assign w_data_sel  = data_in[int'(w_cand)*WIDTH +: WIDTH];

    assign ready_out   = w_xfer ? (NCH'(1) << w_cand) : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_grant   <= '0;
            r_ptr     <= SEL_W'(NCH - 1);
        end else if (w_xfer) begin
            r_y       <= w_data_sel;
            r_y_valid <= 1'b1;
            r_grant   <= w_cand;
            if (mode_in == MODE_RR) begin
                r_ptr <= w_cand;
            end
        end else if (w_free) begin
            r_y_valid <= 1'b0;
        end
    end

    assign y_out       = r_y;
    assign y_valid_out = r_y_valid;
    assign grant_out   = r_grant;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed, table-driven bench for mux_arb_reg (NCH=4, WIDTH=8).
module tb_mux_arb_reg;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             mode_in;
    logic [1:0]       sel_in;
    logic [3:0]       valid_in;
    logic [31:0]      data_in;
    logic [3:0]       ready_out;
    logic [7:0]       y_out;
    logic             y_valid_out;
    logic             y_ready_in;
    logic [1:0]       grant_out;

    int checks = 0;
    int errors = 0;

    mux_arb_reg #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .mode_in     (mode_in),
        .sel_in      (sel_in),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .y_out       (y_out),
        .y_valid_out (y_valid_out),
        .y_ready_in  (y_ready_in),
        .grant_out   (grant_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        yr;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_y;
        logic        exp_yv;
        logic [1:0]  exp_g;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic mode, logic [1:0] sel, logic [3:0] valid,
                                logic [31:0] data, logic yr, logic [3:0] er,
                                logic [7:0] ey, logic eyv, logic [1:0] eg);
        vec_t v;
        v.mode = mode; v.sel = sel; v.valid = valid; v.data = data; v.yr = yr;
        v.exp_ready = er; v.exp_y = ey; v.exp_yv = eyv; v.exp_g = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic eyv, input logic [1:0] eg);
        chk({tag, " y_out"}, 32'(y_out), 32'(ey));
        chk({tag, " y_valid_out"}, 32'(y_valid_out), 32'(eyv));
        chk({tag, " grant_out"}, 32'(grant_out), 32'(eg));
    endtask

    localparam logic F = 1'b0;
    localparam logic R = 1'b1;
    localparam logic [31:0] D_INC = 32'h13121110;

    initial begin
        // reset through fixed select, RR sweep, backpressure, idle select, wrap, mode change
        vecs[0]  = mk(F, 2'd2, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 8'hA5, 1'b1, 2'd2);
        vecs[1]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0001, 8'h10, 1'b1, 2'd0);
        vecs[2]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0010, 8'h11, 1'b1, 2'd1);
        vecs[3]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0100, 8'h12, 1'b1, 2'd2);
        vecs[4]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b1, 4'b1000, 8'h13, 1'b1, 2'd3);
        vecs[5]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0001, 8'h10, 1'b1, 2'd0);
        vecs[6]  = mk(R, 2'd0, 4'b0010, 32'h00003C00, 1'b1, 4'b0010, 8'h3C, 1'b1, 2'd1);
        vecs[7]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b0, 4'b0000, 8'h3C, 1'b1, 2'd1);
        vecs[8]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b0, 4'b0000, 8'h3C, 1'b1, 2'd1);
        vecs[9]  = mk(R, 2'd0, 4'b1111, D_INC,        1'b0, 4'b0000, 8'h3C, 1'b1, 2'd1);
        vecs[10] = mk(R, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0100, 8'h12, 1'b1, 2'd2);
        vecs[11] = mk(F, 2'd1, 4'b1101, D_INC,        1'b0, 4'b0000, 8'h12, 1'b1, 2'd2);
        vecs[12] = mk(F, 2'd1, 4'b1101, D_INC,        1'b1, 4'b0000, 8'h12, 1'b0, 2'd2);
        vecs[13] = mk(F, 2'd1, 4'b1101, D_INC,        1'b1, 4'b0000, 8'h12, 1'b0, 2'd2);
        vecs[14] = mk(R, 2'd0, 4'b1000, D_INC,        1'b1, 4'b1000, 8'h13, 1'b1, 2'd3);
        vecs[15] = mk(R, 2'd0, 4'b0101, D_INC,        1'b1, 4'b0001, 8'h10, 1'b1, 2'd0);
        vecs[16] = mk(R, 2'd0, 4'b0101, D_INC,        1'b1, 4'b0100, 8'h12, 1'b1, 2'd2);
        vecs[17] = mk(R, 2'd0, 4'b0101, D_INC,        1'b1, 4'b0001, 8'h10, 1'b1, 2'd0);
        vecs[18] = mk(F, 2'd3, 4'b1111, D_INC,        1'b1, 4'b1000, 8'h13, 1'b1, 2'd3);
        vecs[19] = mk(R, 2'd0, 4'b1111, D_INC,        1'b1, 4'b0010, 8'h11, 1'b1, 2'd1);

        rst_n_in   = 1'b0;
        mode_in    = F;
        sel_in     = 2'd0;
        valid_in   = 4'b0000;
        data_in    = '0;
        y_ready_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        chk_out("reset", 8'h00, 1'b0, 2'd0);
        chk("reset ready_out", 32'(ready_out), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 20; i++) begin
            mode_in    = vecs[i].mode;
            sel_in     = vecs[i].sel;
            valid_in   = vecs[i].valid;
            data_in    = vecs[i].data;
            y_ready_in = vecs[i].yr;
            #1;
            chk($sformatf("vec%0d ready_out", i), 32'(ready_out), 32'(vecs[i].exp_ready));
            @(posedge clk_in);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_yv, vecs[i].exp_g);
        end

        // async reset while a word is held under backpressure
        y_ready_in = 1'b0;
        valid_in   = 4'b0000;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk_out("midreset", 8'h00, 1'b0, 2'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("post-reset idle y_valid_out", 32'(y_valid_out), 32'h0);
        mode_in    = R;
        valid_in   = 4'b1111;
        data_in    = D_INC;
        y_ready_in = 1'b1;
        #1;
        chk("post-reset rr ready_out", 32'(ready_out), 32'h1);
        @(posedge clk_in);
        #1;
        chk_out("post-reset rr", 8'h10, 1'b1, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

endmodule
